mips32_rtype_issuer: RTL

MIPS32_RTYPE_ISSUER -- requirements
Module: mips32_rtype_issuer

---
 rtl/mips32_rtype_issuer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mips32_rtype_issuer.sv
// Queues R-type field requests, encodes them into MIPS32 words and issues them one at a time
// to an executor, returning the result (or a timeout marker) as a one-cycle response.
module mips32_rtype_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_funct_i,
    input  logic [4:0]  req_rs_i,
    input  logic [4:0]  req_rt_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_shamt_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    input  logic        res_valid_i,
    input  logic [31:0] res_i,
    output logic        rsp_valid_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        bad_funct_o,
    output logic [7:0]  issued_cnt_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q;
    logic [25:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          bad_funct_q;
    logic [31:0]   instr_q;
    logic          instr_valid_q;
    logic          rsp_valid_q;
    logic [4:0]    rsp_rd_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_timeout_q;
    logic [7:0]    issued_q;
    logic [TW-1:0] tmo_q;

    logic funct_ok, accept, push, pop;

    always_comb begin
        funct_ok = 1'b0;
        case (req_funct_i)
            6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
            6'b100101, 6'b100111, 6'b000000, 6'b000010, 6'b101011: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    assign req_ready_o = (count_q != CW'(DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && funct_ok;
    assign pop         = (state_q == StIdle) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage is not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bad_funct_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            bad_funct_q <= accept && !funct_ok;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_q      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            issued_q      <= '0;
            tmo_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        instr_q       <= {6'b000000, mem_q[rd_ptr_q]};
                        instr_valid_q <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        issued_q      <= issued_q + 8'd1;
                        tmo_q         <= '0;
                        state_q       <= StWait;
                    end
                end
                StWait: begin
                    if (res_valid_i) begin
                        rsp_data_q    <= res_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rd_q      <= instr_q[15:11];
                        state_q       <= StResp;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_rd_q      <= instr_q[15:11];
                        state_q       <= StResp;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                StResp: begin
                    rsp_valid_q   <= 1'b0;
                    rsp_timeout_q <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rd_o      = rsp_rd_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign bad_funct_o   = bad_funct_q;
    assign issued_cnt_o  = issued_q;
endmodule
